// File: rtl/sr_latch_driver_pkg.sv
// Shared state type, default timing constants and width helpers for the SR latch driver.
`timescale 1ns/1ps
package sr_drv_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} sr_state_t;

    localparam int unsigned SR_PULSE_CYCLES_DEF = 4;
    localparam int unsigned SR_GAP_CYCLES_DEF   = 2;

    function automatic int unsigned sr_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of the shared phase counter; never narrower than one bit.
    function automatic int unsigned sr_cnt_w(input int unsigned p, input int unsigned g);
        int unsigned w;
        w = $clog2(sr_max(p, g) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/response handshake between control logic and the SR latch driver.
`timescale 1ns/1ps
interface sr_latch_driver_if #(
    parameter int unsigned IDX_W = 3
);

    logic             req_valid;
    logic             req_ready;
    logic             req_clr;
    logic [IDX_W-1:0] req_idx;
    logic             req_val;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_clr, req_idx, req_val,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_clr, req_idx, req_val,
        output req_ready, done, err
    );

endinterface

// File: rtl/sr_latch_driver_cycle_timer.sv
// Loadable down-counter; o_expire marks the last cycle of a loaded interval.
`timescale 1ns/1ps
module cycle_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/sr_latch_driver.sv
// Timed, mutually exclusive s/r pulse driver for a bank of N SR latches.
// Optional macro SR_VERIFY_EN enables q_in read-back checking in the CHECK state.
`timescale 1ns/1ps
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned PULSE_CYCLES = SR_PULSE_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES   = SR_GAP_CYCLES_DEF,
    parameter int unsigned IDX_W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sr_latch_driver_if.slave bus,
    output logic [N-1:0]     s,
    output logic [N-1:0]     r,
    input  logic [N-1:0]     q_in
);

    localparam int unsigned    CW   = sr_cnt_w(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [IDX_W:0] LP_N = (IDX_W + 1)'(N);

    sr_state_t        r_state, w_state_nxt;
    logic             r_clr, r_val, r_oor;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_s, r_r, w_s_nxt, w_r_nxt;
    logic             w_accept, w_req_oor, w_load, w_expire, w_mismatch;
    logic [CW-1:0]    w_load_val;

    assign w_accept  = bus.req_valid && (r_state == IDLE);
    assign w_req_oor = ({1'b0, bus.req_idx} >= LP_N);

    cycle_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = CW'(PULSE_CYCLES);
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_oor) begin
                        w_state_nxt = CHECK;
                    end else begin
                        w_state_nxt = PULSE;
                        w_load      = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (w_expire) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = CHECK;
                    end else begin
                        w_state_nxt = GAP;
                        w_load      = 1'b1;
                        w_load_val  = CW'(GAP_CYCLES);
                    end
                end
            end
            GAP: begin
                if (w_expire) w_state_nxt = CHECK;
            end
            CHECK: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pattern is built from the live request at acceptance so s/r rise in the
    // first PULSE cycle, then held while PULSE continues; any other state forces zero.
    always_comb begin
        w_s_nxt = '0;
        w_r_nxt = '0;
        if (w_accept && !w_req_oor) begin
            if (bus.req_clr) begin
                w_r_nxt = '1;
            end else if (bus.req_val) begin
                w_s_nxt[bus.req_idx] = 1'b1;
            end else begin
                w_r_nxt[bus.req_idx] = 1'b1;
            end
        end else if ((r_state == PULSE) && (w_state_nxt == PULSE)) begin
            w_s_nxt = r_s;
            w_r_nxt = r_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_r     <= '0;
            r_clr   <= 1'b0;
            r_val   <= 1'b0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_r     <= w_r_nxt;
            if (w_accept) begin
                r_clr <= bus.req_clr;
                r_val <= bus.req_val;
                r_idx <= bus.req_idx;
                r_oor <= w_req_oor;
            end
        end
    end

`ifdef SR_VERIFY_EN
    always_comb begin
        w_mismatch = 1'b0;
        if (!r_oor) begin
            if (r_clr) begin
                w_mismatch = (q_in != '0);
            end else begin
                w_mismatch = (q_in[r_idx] != r_val);
            end
        end
    end
`else
    logic w_unused_q;
    assign w_unused_q = ^{q_in, r_clr, r_val, r_idx};
    assign w_mismatch = 1'b0;
`endif

    assign bus.req_ready = (r_state == IDLE);
    assign bus.done      = (r_state == CHECK);
    assign bus.err       = (r_state == CHECK) && (r_oor || w_mismatch);
    assign s             = r_s;
    assign r             = r_r;

endmodule
